manual_drive_ctrl: RTL and testbench
====================================

MANUAL_DRIVE_CTRL -- requirements
Module: manual_drive_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 100000000; cycles power_on must be held to power up.
REQ-002 SHALL have parameter TICK_CYCLES, default 100000000; cycles per mileage increment while moving.
REQ-003 SHALL have parameter BLINK_CYCLES, default 50000000; half-period of the turn indicator blink.
REQ-004 SHALL have parameter MILEAGE_W, default 32; mileage counter width.
REQ-005 sys_clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 power_on, power_off  in  1 each  power buttons, already synchronised and debounced.
REQ-008 mode  in  3  drive mode select; 3'b001 = manual.
REQ-009 clutch, throttle, brake, reverse, bu_left, bu_right  in  1 each  driver controls, level-sensitive.
REQ-010 powered  out  1  vehicle powered.
REQ-011 drive_state  out  2  00 OFF, 01 NOT_STARTING, 10 STARTING, 11 MOVING.
REQ-012 move_fwd, move_back, turn_left, turn_right  out  1 each  motion commands to the simulator link.
REQ-013 led_left, led_right  out  1 each  blinking indicators.
REQ-014 mileage  out  MILEAGE_W  accumulated distance ticks.

Function
REQ-015 SHALL count consecutive cycles with power_on=1 while OFF, and enter NOT_STARTING on the cycle the count reaches HOLD_CYCLES; releasing power_on early SHALL clear the count.
REQ-016 SHALL give power_off=1 priority over every other input: next state OFF from any state.
REQ-017 Transitions apply only when mode==3'b001; any other mode SHALL freeze drive_state and force all four motion outputs to 0. power_on/power_off SHALL act in every mode.
REQ-018 NOT_STARTING: throttle=1 & clutch=0 -> OFF (stall); throttle=1 & clutch=1 & brake=0 -> STARTING; otherwise hold.
REQ-019 STARTING: brake=1 -> NOT_STARTING; throttle=1 & clutch=0 -> MOVING; otherwise hold.
REQ-020 MOVING: reverse level differing from its value on the previous cycle with clutch=0 -> OFF; brake=1 -> NOT_STARTING; clutch=1 or throttle=0 -> STARTING; otherwise hold. This priority order is fixed.
REQ-021 move_fwd = MOVING & reverse=0; move_back = MOVING & reverse=1; both registered from state, zero latency relative to drive_state.
REQ-022 turn_left = bu_left & ~bu_right & state in {STARTING, MOVING}; turn_right symmetric; both pressed -> neither.
REQ-023 Blink counter SHALL free-run while powered and toggle a phase bit every BLINK_CYCLES; led_left = bu_left & phase & powered; led_right symmetric.
REQ-024 Tick counter SHALL advance only in MOVING, clear on leaving MOVING, and on reaching TICK_CYCLES increment mileage by 1 and restart.
REQ-025 mileage SHALL wrap from all-ones to 0; it SHALL NOT clear on OFF, only on rst.
REQ-026 powered = (drive_state != OFF).
REQ-027 power_on and power_off both 1 -> power_off wins, hold count cleared.

Reset
REQ-028 rst SHALL asynchronously force drive_state OFF, all counters 0, mileage 0, blink phase 0, previous-reverse register 0, all outputs 0.
REQ-029 rst asserted mid-MOVING SHALL drop move_fwd/move_back within the same cycle, with no clock edge required.

Structure
REQ-030 The state encodings and the mode code 3'b001 SHALL be constants in the shared car_pkg package, used by this block and the simulator wrapper.
REQ-031 A single sub-module, cycle_timer (parameterised terminal count, enable, clear, done pulse), SHALL be instantiated three times: hold, tick and blink.

Verification (bench overrides HOLD_CYCLES=4, TICK_CYCLES=8, BLINK_CYCLES=3, MILEAGE_W=4)
REQ-032 power_on held 4 cycles -> drive_state 01 on the 4th edge; power_on held 3 cycles then released -> stays 00.
REQ-033 NOT_STARTING, clutch=1+throttle=1 -> 10; clutch=0 while throttle stays 1 -> 11, move_fwd=1; after 16 cycles mileage=2.
REQ-034 MOVING, toggle reverse with clutch=0 -> 00 next edge, motion outputs 0; repeat with clutch=1 -> 10, then move_back=1 after clutch release.
REQ-035 MOVING with mileage=15, 8 more cycles -> mileage wraps to 0; then power_off -> 00 with mileage held.
REQ-036 mode=3'b010 while MOVING -> motion outputs 0, drive_state frozen at 11; power_off still -> 00.
REQ-037 bu_left=1 while powered -> led_left toggles every 3 cycles; rst asserted between edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/car_pkg.sv
// car_pkg: drive-state encodings and mode codes shared by the drive controller and the simulator wrapper.
//   drive_state_t : 2-bit drive state (OFF, NOT_STARTING, STARTING, MOVING)
//   MODE_MANUAL   : mode select value for manual driving
package car_pkg;

   typedef enum logic [1:0] {
      ST_OFF          = 2'b00,
      ST_NOT_STARTING = 2'b01,
      ST_STARTING     = 2'b10,
      ST_MOVING       = 2'b11
   } drive_state_t;

   localparam logic [2:0] MODE_MANUAL = 3'b001;

endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: counts enabled cycles and pulses done on the N-th one, then restarts.
//   clk, rst : clock and asynchronous active-high reset
//   en       : count this cycle
//   clr      : synchronous clear, wins over en
//   done     : combinational pulse on the cycle the count reaches N
module cycle_timer #(
   parameter int N = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic done
);

   localparam int W = (N > 1) ? $clog2(N) : 1;

   logic [W-1:0] cnt;

   assign done = en & ~clr & (cnt == W'(N - 1));

   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr || done) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;

endmodule

// File: rtl/manual_drive_ctrl.sv
// manual_drive_ctrl: manual-mode drive state machine with power hold, blinkers and mileage.
//   sys_clk, rst                 : clock, asynchronous active-high reset
//   power_on, power_off          : power buttons (power_off dominates)
//   mode                         : drive mode select, manual = MODE_MANUAL
//   clutch..bu_right             : level-sensitive driver controls
//   powered, drive_state         : power flag and current drive state
//   move_*, turn_*               : motion commands, zero outside manual mode
//   led_left, led_right          : blinking turn indicators
//   mileage                      : wrapping distance tick count
module manual_drive_ctrl
   import car_pkg::*;
#(
   parameter int HOLD_CYCLES  = 100000000,
   parameter int TICK_CYCLES  = 100000000,
   parameter int BLINK_CYCLES = 50000000,
   parameter int MILEAGE_W    = 32
) (
   input  logic                 sys_clk,
   input  logic                 rst,
   input  logic                 power_on,
   input  logic                 power_off,
   input  logic [2:0]           mode,
   input  logic                 clutch,
   input  logic                 throttle,
   input  logic                 brake,
   input  logic                 reverse,
   input  logic                 bu_left,
   input  logic                 bu_right,
   output logic                 powered,
   output logic [1:0]           drive_state,
   output logic                 move_fwd,
   output logic                 move_back,
   output logic                 turn_left,
   output logic                 turn_right,
   output logic                 led_left,
   output logic                 led_right,
   output logic [MILEAGE_W-1:0] mileage
);

   drive_state_t state, nxt;
   logic prev_rev, phase;
   logic hold_en, hold_done, tick_done, blink_done;
   logic manual, moving, turning, rev_chg;

   assign manual  = (mode == MODE_MANUAL);
   assign moving  = (state == ST_MOVING);
   assign turning = (state == ST_STARTING) | moving;
   assign rev_chg = reverse ^ prev_rev;
   assign powered = (state != ST_OFF);
   // The hold count only survives uninterrupted solo presses of power_on while off.
   assign hold_en = (state == ST_OFF) & power_on & ~power_off;

   cycle_timer #(.N(HOLD_CYCLES)) u_hold (
      .clk(sys_clk), .rst(rst), .en(hold_en), .clr(~hold_en), .done(hold_done)
   );

   cycle_timer #(.N(TICK_CYCLES)) u_tick (
      .clk(sys_clk), .rst(rst), .en(moving), .clr(~moving), .done(tick_done)
   );

   cycle_timer #(.N(BLINK_CYCLES)) u_blink (
      .clk(sys_clk), .rst(rst), .en(powered), .clr(~powered), .done(blink_done)
   );

   always_comb begin
      nxt = state;
      if (power_off) nxt = ST_OFF;
      else if (state == ST_OFF) nxt = hold_done ? ST_NOT_STARTING : ST_OFF;
      else if (manual)
         case (state)
            ST_NOT_STARTING: nxt = (throttle & ~clutch) ? ST_OFF :
                                   (throttle & clutch & ~brake) ? ST_STARTING : state;
            ST_STARTING:     nxt = brake ? ST_NOT_STARTING :
                                   (throttle & ~clutch) ? ST_MOVING : state;
            ST_MOVING:       nxt = (rev_chg & ~clutch) ? ST_OFF :
                                   brake ? ST_NOT_STARTING :
                                   (clutch | ~throttle) ? ST_STARTING : state;
            default:         nxt = state;
         endcase
   end

   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         state    <= ST_OFF;
         prev_rev <= 1'b0;
         phase    <= 1'b0;
         mileage  <= '0;
      end else begin
         state    <= nxt;
         prev_rev <= reverse;
         phase    <= phase ^ blink_done;
         if (tick_done) mileage <= mileage + 1'b1;
      end

   // Outputs decode the state register directly so an async reset clears them at once.
   assign drive_state = state;
   assign move_fwd    = manual & moving & ~reverse;
   assign move_back   = manual & moving & reverse;
   assign turn_left   = manual & turning & bu_left & ~bu_right;
   assign turn_right  = manual & turning & bu_right & ~bu_left;
   assign led_left    = bu_left & phase & powered;
   assign led_right   = bu_right & phase & powered;

endmodule

// File: tb/tb_manual_drive_ctrl.sv
// tb_manual_drive_ctrl: directed self-checking bench for manual_drive_ctrl.
module tb_manual_drive_ctrl;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b0;
   logic       power_on, power_off;
   logic [2:0] mode;
   logic       clutch, throttle, brake, reverse, bu_left, bu_right;
   logic       powered, move_fwd, move_back, turn_left, turn_right, led_left, led_right;
   logic [1:0] drive_state;
   logic [3:0] mileage;

   int n_cmp = 0;
   int n_fail = 0;

   always #5 sys_clk = ~sys_clk;

   manual_drive_ctrl #(
      .HOLD_CYCLES(4), .TICK_CYCLES(8), .BLINK_CYCLES(3), .MILEAGE_W(4)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .power_on(power_on), .power_off(power_off),
      .mode(mode), .clutch(clutch), .throttle(throttle), .brake(brake),
      .reverse(reverse), .bu_left(bu_left), .bu_right(bu_right),
      .powered(powered), .drive_state(drive_state), .move_fwd(move_fwd),
      .move_back(move_back), .turn_left(turn_left), .turn_right(turn_right),
      .led_left(led_left), .led_right(led_right), .mileage(mileage)
   );

   task automatic step(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic do_reset();
      power_on = 0; power_off = 0; mode = 3'b001;
      clutch = 0; throttle = 0; brake = 0; reverse = 0; bu_left = 0; bu_right = 0;
      rst = 1;
      step(1);
      rst = 0;
   endtask

   task automatic power_up();
      power_on = 1;
      step(4);
      power_on = 0;
   endtask

   task automatic to_moving();
      throttle = 0; clutch = 0; brake = 0;
      power_up();
      throttle = 1; clutch = 1;
      step(1);
      clutch = 0;
      step(1);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL reset_state got %b want 00", drive_state); end
      n_cmp++; if (powered !== 1'b0) begin n_fail++; $display("FAIL reset_powered got %b want 0", powered); end
      n_cmp++; if (mileage !== 4'd0) begin n_fail++; $display("FAIL reset_mileage got %0d want 0", mileage); end
      n_cmp++; if ({move_fwd, move_back, turn_left, turn_right, led_left, led_right} !== 6'b0)
         begin n_fail++; $display("FAIL reset_outputs got %b want 000000",
            {move_fwd, move_back, turn_left, turn_right, led_left, led_right}); end
   endtask

   task automatic test_power();
      do_reset();
      power_on = 1; step(3); power_on = 0; step(2);
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL early_release got %b want 00", drive_state); end
      power_on = 1; step(2); power_off = 1; step(1); power_off = 0; step(3);
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL both_pressed_clear got %b want 00", drive_state); end
      step(1);
      n_cmp++; if (drive_state !== 2'b01) begin n_fail++; $display("FAIL hold_4th_edge got %b want 01", drive_state); end
      n_cmp++; if (powered !== 1'b1) begin n_fail++; $display("FAIL powered_on got %b want 1", powered); end
      power_off = 1; step(1); power_on = 0; power_off = 0;
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL power_off got %b want 00", drive_state); end
   endtask

   task automatic test_stall();
      do_reset();
      power_up();
      throttle = 1; clutch = 0; step(1);
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL stall got %b want 00", drive_state); end
      throttle = 0; power_up();
      throttle = 1; clutch = 1; step(1);
      n_cmp++; if (drive_state !== 2'b10) begin n_fail++; $display("FAIL start got %b want 10", drive_state); end
      brake = 1; step(1);
      n_cmp++; if (drive_state !== 2'b01) begin n_fail++; $display("FAIL starting_brake got %b want 01", drive_state); end
   endtask

   task automatic test_drive();
      do_reset();
      to_moving();
      n_cmp++; if (drive_state !== 2'b11) begin n_fail++; $display("FAIL moving got %b want 11", drive_state); end
      n_cmp++; if ({move_fwd, move_back} !== 2'b10) begin n_fail++; $display("FAIL move_fwd got %b want 10", {move_fwd, move_back}); end
      step(15);
      n_cmp++; if (mileage !== 4'd1) begin n_fail++; $display("FAIL mileage_15 got %0d want 1", mileage); end
      step(1);
      n_cmp++; if (mileage !== 4'd2) begin n_fail++; $display("FAIL mileage_16 got %0d want 2", mileage); end
   endtask

   task automatic test_reverse();
      do_reset();
      to_moving();
      reverse = 1; step(1);
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL rev_stall got %b want 00", drive_state); end
      n_cmp++; if ({move_fwd, move_back} !== 2'b00) begin n_fail++; $display("FAIL rev_stall_motion got %b want 00", {move_fwd, move_back}); end
      reverse = 0;
      to_moving();
      reverse = 1; clutch = 1; step(1);
      n_cmp++; if (drive_state !== 2'b10) begin n_fail++; $display("FAIL rev_clutch got %b want 10", drive_state); end
      clutch = 0; step(1);
      n_cmp++; if (drive_state !== 2'b11) begin n_fail++; $display("FAIL rev_remove got %b want 11", drive_state); end
      n_cmp++; if ({move_fwd, move_back} !== 2'b01) begin n_fail++; $display("FAIL move_back got %b want 01", {move_fwd, move_back}); end
   endtask

   task automatic test_wrap();
      do_reset();
      to_moving();
      step(120);
      n_cmp++; if (mileage !== 4'd15) begin n_fail++; $display("FAIL mileage_max got %0d want 15", mileage); end
      step(8);
      n_cmp++; if (mileage !== 4'd0) begin n_fail++; $display("FAIL mileage_wrap got %0d want 0", mileage); end
      step(8);
      power_off = 1; step(1); power_off = 0; step(3);
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL wrap_off got %b want 00", drive_state); end
      n_cmp++; if (mileage !== 4'd1) begin n_fail++; $display("FAIL mileage_held got %0d want 1", mileage); end
   endtask

   task automatic test_mode();
      do_reset();
      to_moving();
      bu_left = 1; #1;
      n_cmp++; if ({turn_left, turn_right} !== 2'b10) begin n_fail++; $display("FAIL turn_left got %b want 10", {turn_left, turn_right}); end
      bu_right = 1; #1;
      n_cmp++; if ({turn_left, turn_right} !== 2'b00) begin n_fail++; $display("FAIL turn_both got %b want 00", {turn_left, turn_right}); end
      bu_right = 0; mode = 3'b010; #1;
      n_cmp++; if ({move_fwd, move_back, turn_left, turn_right} !== 4'b0)
         begin n_fail++; $display("FAIL mode_motion got %b want 0000", {move_fwd, move_back, turn_left, turn_right}); end
      throttle = 0; step(2);
      n_cmp++; if (drive_state !== 2'b11) begin n_fail++; $display("FAIL mode_frozen got %b want 11", drive_state); end
      power_off = 1; step(1); power_off = 0;
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL mode_power_off got %b want 00", drive_state); end
      mode = 3'b001;
   endtask

   task automatic test_blink();
      logic [9:0] want;
      do_reset();
      bu_left = 1;
      power_up();
      want = 10'b1000111000;
      for (int k = 0; k < 8; k++) begin
         n_cmp++; if (led_left !== want[k]) begin n_fail++; $display("FAIL blink_k%0d got %b want %b", k, led_left, want[k]); end
         step(1);
      end
      step(1);
      n_cmp++; if (led_left !== want[9]) begin n_fail++; $display("FAIL blink_k9 got %b want %b", led_left, want[9]); end
      n_cmp++; if (led_right !== 1'b0) begin n_fail++; $display("FAIL led_right got %b want 0", led_right); end
      #2 rst = 1; #1;
      n_cmp++; if ({powered, led_left, drive_state} !== 4'b0) begin n_fail++; $display("FAIL async_rst_blink got %b want 0000", {powered, led_left, drive_state}); end
      rst = 0;
   endtask

   task automatic test_async_reset();
      do_reset();
      to_moving();
      step(9);
      #2 rst = 1; #1;
      n_cmp++; if ({move_fwd, move_back} !== 2'b00) begin n_fail++; $display("FAIL async_rst_motion got %b want 00", {move_fwd, move_back}); end
      n_cmp++; if (drive_state !== 2'b00) begin n_fail++; $display("FAIL async_rst_state got %b want 00", drive_state); end
      n_cmp++; if (mileage !== 4'd0) begin n_fail++; $display("FAIL async_rst_mileage got %0d want 0", mileage); end
      rst = 0;
      step(1);
   endtask

   initial begin
      test_reset();
      test_power();
      test_stall();
      test_drive();
      test_reverse();
      test_wrap();
      test_mode();
      test_blink();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
